// File: rtl/guess_game_ctrl.sv
// guess_game_ctrl: two-player number-guessing sequencer driving both 7-seg pairs and the LEDs.
// Define GUESS_HINT_EN to show a higher/lower hint on the LEDs while a miss is displayed.
module guess_game_ctrl #(
  parameter int MAX_TRIES  = 5,
  parameter int RESULT_CYC = 50000000,
  parameter int CNT_W      = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] p1_val,
  input  logic [3:0] p2_val,
  input  logic       p1_btn,
  input  logic       p2_btn,
  output logic [3:0] p1_disp,
  output logic [3:0] p2_disp,
  output logic       p1_blank,
  output logic [3:0] tries_left,
  output logic [9:0] led,
  output logic [2:0] state_o
);
  typedef enum logic [2:0] {IDLE = 3'd0, ARMED = 3'd1, CHECK = 3'd2, RESULT = 3'd3, WIN = 3'd4, OVER = 3'd5} state_t;
  state_t state_q, state_d;
  logic [3:0] secret_q, secret_d, guess_q, guess_d, tries_q, tries_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic p1_btn_q, p2_btn_q, p1_press, p2_press;
  logic [9:0] miss_led;
  assign p1_press = p1_btn & ~p1_btn_q;
  assign p2_press = p2_btn & ~p2_btn_q;
  always_comb begin
    state_d  = state_q;
    secret_d = secret_q;
    guess_d  = guess_q;
    tries_d  = tries_q;
    cnt_d    = cnt_q;
    if (state_q != IDLE && p1_press) state_d = IDLE;
    else
      case (state_q)
        IDLE: if (p1_press) begin
          secret_d = p1_val;
          tries_d  = 4'(MAX_TRIES);
          state_d  = ARMED;
        end
        ARMED: if (p2_press) begin
          guess_d = p2_val;
          state_d = CHECK;
        end
        CHECK: if (guess_q == secret_q) state_d = WIN;
        else begin
          tries_d = tries_q - 4'(tries_q != 4'd0);
          cnt_d   = CNT_W'(RESULT_CYC - 1);
          state_d = tries_q <= 4'd1 ? OVER : RESULT;
        end
        RESULT: begin
          cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - CNT_W'(1);
          state_d = cnt_q == '0 ? ARMED : RESULT;
        end
        default: ;
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      secret_q <= '0;
      guess_q  <= '0;
      tries_q  <= 4'(MAX_TRIES);
      cnt_q    <= '0;
      p1_btn_q <= 1'b0;
      p2_btn_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      secret_q <= secret_d;
      guess_q  <= guess_d;
      tries_q  <= tries_d;
      cnt_q    <= cnt_d;
      p1_btn_q <= p1_btn;
      p2_btn_q <= p2_btn;
    end
  end
`ifdef GUESS_HINT_EN
  assign miss_led = guess_q > secret_q ? 10'h3E0 : 10'h01F;
`else
  assign miss_led = 10'h000;
`endif
  // The secret stays hidden from the moment it is locked until the round is decided.
  assign p1_blank   = state_q == ARMED || state_q == CHECK || state_q == RESULT;
  assign p1_disp    = state_q == IDLE ? p1_val : secret_q;
  assign p2_disp    = p2_val;
  assign tries_left = tries_q;
  assign led        = state_q == WIN ? 10'h3FF : state_q == OVER ? 10'h2AA : state_q == RESULT ? miss_led : 10'h000;
  assign state_o    = state_q;
endmodule

// File: tb/tb_guess_game_ctrl.sv
// tb_guess_game_ctrl: directed and randomized checks of guess_game_ctrl against round-level expectations.
module tb_guess_game_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] p1_val = '0, p2_val = '0;
  logic p1_btn = 1'b0, p2_btn = 1'b0;
  logic [3:0] p1_disp, p2_disp, tries_left, b_p1_disp, b_p2_disp, b_tries;
  logic p1_blank, b_p1_blank;
  logic [9:0] led, b_led;
  logic [2:0] st, b_st;
  int checks = 0;
  int failures = 0;
`ifdef GUESS_HINT_EN
  localparam bit HINT = 1'b1;
`else
  localparam bit HINT = 1'b0;
`endif

  guess_game_ctrl #(.MAX_TRIES(5), .RESULT_CYC(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .p1_val(p1_val), .p2_val(p2_val), .p1_btn(p1_btn), .p2_btn(p2_btn),
    .p1_disp(p1_disp), .p2_disp(p2_disp), .p1_blank(p1_blank), .tries_left(tries_left), .led(led), .state_o(st));

  guess_game_ctrl #(.MAX_TRIES(2), .RESULT_CYC(4), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .p1_val(p1_val), .p2_val(p2_val), .p1_btn(p1_btn), .p2_btn(p2_btn),
    .p1_disp(b_p1_disp), .p2_disp(b_p2_disp), .p1_blank(b_p1_blank), .tries_left(b_tries), .led(b_led), .state_o(b_st));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout no completion");
    $fatal(1);
  end

  function automatic logic [9:0] miss_led(input logic [3:0] g, input logic [3:0] s);
    return HINT ? (g > s ? 10'h3E0 : 10'h01F) : 10'h000;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    p1_btn = 1'b0;
    p2_btn = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic press_p1(input logic [3:0] v);
    p1_btn = 1'b0;
    step(1);
    p1_val = v;
    p1_btn = 1'b1;
    step(1);
    p1_btn = 1'b0;
  endtask

  task automatic press_p2(input logic [3:0] v);
    p2_btn = 1'b0;
    step(1);
    p2_val = v;
    p2_btn = 1'b1;
    step(1);
    p2_btn = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (st !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", st); end
    checks++; if (tries_left !== 4'd5) begin failures++; $display("FAIL reset_tries got=%0d exp=5", tries_left); end
    checks++; if (led !== 10'h000) begin failures++; $display("FAIL reset_led got=%h exp=000", led); end
    checks++; if (p1_blank !== 1'b0) begin failures++; $display("FAIL reset_blank got=%b exp=0", p1_blank); end
  endtask

  task automatic test_win();
    press_p1(4'd7);
    checks++; if (st !== 3'd1 || p1_blank !== 1'b1) begin failures++; $display("FAIL win_armed got=%0d/%b exp=1/1", st, p1_blank); end
    press_p2(4'd7);
    checks++; if (st !== 3'd2) begin failures++; $display("FAIL win_check got=%0d exp=2", st); end
    step(1);
    checks++; if (st !== 3'd4) begin failures++; $display("FAIL win_state got=%0d exp=4", st); end
    checks++; if (led !== 10'h3FF) begin failures++; $display("FAIL win_led got=%h exp=3ff", led); end
    checks++; if (tries_left !== 4'd5 || p1_disp !== 4'd7 || p1_blank !== 1'b0) begin failures++; $display("FAIL win_disp got=%0d/%0d/%b exp=5/7/0", tries_left, p1_disp, p1_blank); end
  endtask

  task automatic test_miss();
    press_p1(4'd0);
    checks++; if (st !== 3'd0 || led !== 10'h000) begin failures++; $display("FAIL restart got=%0d/%h exp=0/000", st, led); end
    p1_val = 4'd9;
    p2_val = 4'd11;
    step(1);
    checks++; if (p1_disp !== 4'd9 || p2_disp !== 4'd11) begin failures++; $display("FAIL idle_live got=%0d/%0d exp=9/11", p1_disp, p2_disp); end
    press_p1(4'd9);
    press_p2(4'd3);
    step(1);
    checks++; if (st !== 3'd3 || tries_left !== 4'd4) begin failures++; $display("FAIL miss_result got=%0d/%0d exp=3/4", st, tries_left); end
    checks++; if (led !== miss_led(4'd3, 4'd9)) begin failures++; $display("FAIL miss_led got=%h exp=%h", led, miss_led(4'd3, 4'd9)); end
    for (int i = 0; i < 3; i++) begin
      step(1);
      checks++; if (st !== 3'd3) begin failures++; $display("FAIL miss_hold%0d got=%0d exp=3", i, st); end
    end
    step(1);
    checks++; if (st !== 3'd1 || tries_left !== 4'd4) begin failures++; $display("FAIL miss_rearm got=%0d/%0d exp=1/4", st, tries_left); end
  endtask

  task automatic test_over();
    do_reset();
    press_p1(4'd5);
    press_p2(4'd1);
    step(1);
    checks++; if (b_st !== 3'd3 || b_tries !== 4'd1) begin failures++; $display("FAIL over_first got=%0d/%0d exp=3/1", b_st, b_tries); end
    step(4);
    press_p2(4'd12);
    step(1);
    checks++; if (b_st !== 3'd5 || b_led !== 10'h2AA) begin failures++; $display("FAIL over_state got=%0d/%h exp=5/2aa", b_st, b_led); end
    checks++; if (b_tries !== 4'd0 || b_p1_disp !== 4'd5 || b_p1_blank !== 1'b0) begin failures++; $display("FAIL over_disp got=%0d/%0d/%b exp=0/5/0", b_tries, b_p1_disp, b_p1_blank); end
    checks++; if (st !== 3'd3 || tries_left !== 4'd3) begin failures++; $display("FAIL over_wide got=%0d/%0d exp=3/3", st, tries_left); end
    step(6);
    checks++; if (b_st !== 3'd5 || b_tries !== 4'd0) begin failures++; $display("FAIL over_sticky got=%0d/%0d exp=5/0", b_st, b_tries); end
  endtask

  task automatic test_held_button();
    int n_check;
    n_check = 0;
    do_reset();
    press_p1(4'd4);
    p2_btn = 1'b0;
    step(1);
    p2_val = 4'd6;
    p2_btn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (st == 3'd2) n_check++;
    end
    p2_btn = 1'b0;
    checks++; if (n_check != 1) begin failures++; $display("FAIL held_checks got=%0d exp=1", n_check); end
    checks++; if (st !== 3'd1 || tries_left !== 4'd4) begin failures++; $display("FAIL held_end got=%0d/%0d exp=1/4", st, tries_left); end
    press_p2(4'd2);
    step(1);
    press_p2(4'd4);
    checks++; if (st !== 3'd3 || tries_left !== 4'd3) begin failures++; $display("FAIL result_ignore got=%0d/%0d exp=3/3", st, tries_left); end
    step(3);
    checks++; if (st !== 3'd1 || tries_left !== 4'd3) begin failures++; $display("FAIL result_ignore_end got=%0d/%0d exp=1/3", st, tries_left); end
  endtask

  task automatic test_simultaneous();
    p1_btn = 1'b0;
    p2_btn = 1'b0;
    step(1);
    p1_val = 4'd8;
    p2_val = 4'd4;
    p1_btn = 1'b1;
    p2_btn = 1'b1;
    step(1);
    checks++; if (st !== 3'd0 || tries_left !== 4'd3) begin failures++; $display("FAIL both_abort got=%0d/%0d exp=0/3", st, tries_left); end
    p1_btn = 1'b0;
    p2_btn = 1'b0;
    step(2);
    checks++; if (st !== 3'd0 || led !== 10'h000) begin failures++; $display("FAIL both_stay got=%0d/%h exp=0/000", st, led); end
  endtask

  task automatic test_reset_mid();
    press_p1(4'd10);
    press_p2(4'd15);
    step(2);
    checks++; if (st !== 3'd3) begin failures++; $display("FAIL mid_pre got=%0d exp=3", st); end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++; if (st !== 3'd0 || led !== 10'h000 || tries_left !== 4'd5) begin failures++; $display("FAIL mid_rst got=%0d/%h/%0d exp=0/000/5", st, led, tries_left); end
    press_p1(4'd1);
    press_p2(4'd2);
    step(4);
    checks++; if (st !== 3'd3) begin failures++; $display("FAIL mid_hold got=%0d exp=3", st); end
    step(1);
    checks++; if (st !== 3'd1) begin failures++; $display("FAIL mid_rearm got=%0d exp=1", st); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      logic [3:0] s, g;
      int tries;
      bit done;
      s = 4'($urandom_range(0, 15));
      tries = 5;
      done = 1'b0;
      do_reset();
      press_p1(s);
      while (!done) begin
        g = $urandom_range(0, 3) == 0 ? s : 4'($urandom_range(0, 15));
        press_p2(g);
        checks++; if (st !== 3'd2) begin failures++; $display("FAIL rnd_check r=%0d got=%0d exp=2", r, st); end
        step(1);
        if (g == s) begin
          done = 1'b1;
          checks++; if (st !== 3'd4 || led !== 10'h3FF || tries_left !== 4'(tries)) begin failures++; $display("FAIL rnd_win r=%0d got=%0d/%h/%0d exp=4/3ff/%0d", r, st, led, tries_left, tries); end
        end else begin
          tries--;
          if (tries == 0) begin
            done = 1'b1;
            checks++; if (st !== 3'd5 || led !== 10'h2AA || p1_disp !== s || tries_left !== 4'd0) begin failures++; $display("FAIL rnd_over r=%0d got=%0d/%h/%0d exp=5/2aa/%0d", r, st, led, p1_disp, s); end
          end else begin
            checks++; if (st !== 3'd3 || led !== miss_led(g, s) || tries_left !== 4'(tries)) begin failures++; $display("FAIL rnd_miss r=%0d got=%0d/%h/%0d exp=3/%h/%0d", r, st, led, tries_left, miss_led(g, s), tries); end
            step(4);
            checks++; if (st !== 3'd1) begin failures++; $display("FAIL rnd_rearm r=%0d got=%0d exp=1", r, st); end
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_win();
    test_miss();
    test_over();
    test_held_button();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/guess_game_ctrl.md
Name: guess_game_ctrl

Overview:
- Sequences the two-player number game on the DE0 board.
- Player 1 locks a hidden 4-bit secret; player 2 submits guesses from the switches.
- The block compares each guess, counts the remaining tries, and drives the values and blanking for both seven-segment pairs plus the 10 LEDs.
- Sits between the switch/button inputs and the existing seven-segment decoder instances.

Parameters:
- MAX_TRIES, 5, guesses allowed per round; legal range 1..15.
- RESULT_CYC, 50000000, clock cycles a miss result is shown before play resumes (1 s at 50 MHz).
- CNT_W, 26, width of the result-hold counter; must hold RESULT_CYC-1.

Ports:
- clk  input  1  board clock, 50 MHz.
- rst  input  1  synchronous active-high reset.
- p1_val  input  4  player 1 switches.
- p2_val  input  4  player 2 switches.
- p1_btn  input  1  player 1 lock/restart button; active-high level, already debounced.
- p2_btn  input  1  player 2 submit button; active-high level, already debounced.
- p1_disp  output  4  value for the player 1 seven-segment decoder.
- p2_disp  output  4  value for the player 2 seven-segment decoder.
- p1_blank  output  1  1 = player 1 display must be blanked.
- tries_left  output  4  guesses remaining.
- led  output  10  result LEDs.
- state_o  output  3  current state encoding, for debug.

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst` is synchronous and active-high.
- Button edges:
  - Each button passes through one register; press = btn & ~btn_q.
  - A held button generates exactly one press.
- Reset values:
  - state = IDLE.
  - secret = 0, tries_left = MAX_TRIES, hold counter = 0, btn_q = 0.
  - led = 0, p1_blank = 0.
- States (state_o encoding):
  - IDLE = 0
  - ARMED = 1
  - CHECK = 2
  - RESULT = 3
  - WIN = 4
  - OVER = 5
- IDLE:
  - p1_disp = p1_val (live), p1_blank = 0, led = 0.
  - p1 press: latch secret <= p1_val, tries_left <= MAX_TRIES, go to ARMED.
- ARMED:
  - p1_blank = 1, led = 0.
  - p2 press: latch guess <= p2_val, go to CHECK.
- CHECK (exactly 1 cycle):
  - guess == secret: go to WIN.
  - Otherwise tries_left decrements by 1.
    - If the new value is 0, go to OVER.
    - Else load the hold counter with RESULT_CYC-1 and go to RESULT.
- RESULT:
  - Hold counter decrements each cycle; led per miss rule.
  - At counter == 0, go to ARMED.
  - p2 presses are ignored.
- WIN: led = 10'h3FF, p1_blank = 0, p1_disp = secret. Stays until restart.
- OVER: led = 10'h2AA, p1_blank = 0, p1_disp = secret. Stays until restart.
- p2_disp = p2_val in every state.
- Restart/abort:
  - A p1 press in any state other than IDLE goes to IDLE next cycle and clears led.
  - It has priority over a simultaneous p2 press.
- Simultaneous p1+p2 press in IDLE: lock wins; the p2 press is discarded.
- Latency: a p2 press registered at cycle n gives CHECK at n+1 and WIN/OVER/RESULT at n+2.
- tries_left never underflows; it is reloaded only on IDLE->ARMED.
- rst asserted mid-round returns to IDLE with the reset values next edge.

Optional Feature:
- Macro: GUESS_HINT_EN.
- Defined, led during RESULT:
  - guess > secret: led = 10'h3E0.
  - guess < secret: led = 10'h01F.
- Not defined: led = 0 during RESULT.
- WIN/OVER patterns are identical either way.

Test Plan:
1. Reset, p1_val=7, p1 press, p2_val=7, p2 press -> CHECK then WIN two cycles after the registered press; led=3FF, tries_left=5, p1_disp=7, p1_blank=0.
2. Secret 9, guess 3 (RESULT_CYC=4 in bench) -> tries_left=4; RESULT for 4 cycles; then ARMED; led=01F with GUESS_HINT_EN, 000 without.
3. MAX_TRIES=2, secret 5, guesses 1 then 12 -> second CHECK goes to OVER; led=2AA, tries_left=0, p1_disp=5.
4. p2_btn held high 100 cycles in ARMED -> exactly one CHECK; p2 press during RESULT -> ignored, tries_left unchanged.
5. p1 and p2 pressed in the same cycle in ARMED -> IDLE next cycle, tries_left unchanged, no CHECK.
6. rst pulsed during RESULT -> IDLE, led=0, tries_left=5, hold counter=0 on the next edge.
